pwm_audio_demod: RTL and testbench
==================================

// Module: pwm_audio_demod
// PURPOSE
//  Receive side of the audio PWM link. Recovers 8-bit audio samples from a PWM waveform
//  whose period is CYCLE+1 clocks and whose high time is (sample*SCALE)-1 clocks.
//  Measures the high time per period, divides by SCALE, and emits one sample per period.
//  Used for loopback self-test of the audio path and to capture external PWM sources.
// PARAMETERS
//  CYCLE    12500  count terminal value of the sender; nominal period = CYCLE+1 clocks
//  SCALE    49     clocks per sample LSB
//  TOL      64     allowed period deviation, in clocks (+/-)
//  SYNC_N   2      number of synchronizer flops on pwm_in (minimum 2)
// PORTS
//  clk           in   1   system clock
//  rst           in   1   synchronous reset, active-low
//  pwm_in        in   1   asynchronous PWM input
//  sample_out    out  8   recovered sample; holds its value between updates
//  sample_valid  out  1   1-cycle pulse when sample_out updates
//  locked        out  1   period tracking is established
//  period_err    out  1   1-cycle pulse when a period falls outside CYCLE+1 +/- TOL
// BEHAVIOUR
//  - Reset (rst=0 at a clk edge): sample_out=0, sample_valid=0, locked=0, period_err=0.
//    FSM goes to HUNT. All counters clear. The divider aborts.
//  - pwm_in passes through SYNC_N flops to give pwm_s. A rise is pwm_s 0->1. All timing
//    below is counted in clocks of pwm_s.
//  - 14-bit counters: per_cnt counts clocks since the last anchor; hi_cnt counts clocks with
//    pwm_s=1 since the last anchor. Both saturate at 2^14-1.
//  - FSM states: HUNT, TRACK, SILENT.
//    HUNT: on a rise, set anchor (per_cnt=1, hi_cnt=1) and go to TRACK. No output.
//    TRACK, on a rise:
//      - Let P = per_cnt. If |P-(CYCLE+1)| <= TOL, capture H = hi_cnt, start the divider,
//        and set locked=1.
//      - Otherwise pulse period_err, set locked=0, and skip the capture.
//      - Re-anchor in both cases.
//    TRACK, no rise: if per_cnt reaches CYCLE+1+TOL:
//      - pwm_s=0 and locked=1: emit sample 0, go to SILENT, set per_cnt=0.
//      - otherwise (stuck high or not locked): pulse period_err, set locked=0, go to HUNT.
//    SILENT: emit sample 0 each time per_cnt reaches CYCLE+1, then restart per_cnt.
//      On a rise, re-anchor and go to TRACK. locked stays 1. That first period is not
//      checked against TOL.
//  - Decode: dividend = H + 1 + SCALE/2. The quotient is clamped to 255. The ideal
//    sender gives an exact round-trip.
//  - Latency: sample_valid is asserted exactly 15 clocks after the rise-detect cycle that
//    captured H (14-step restoring divide plus 1 output register). Silent zeros are
//    registered and have 1 cycle of latency.
//  - The divider is busy for 15 cycles, far below the minimum legal period. A capture
//    request while busy is dropped and period_err is pulsed (glitch protection).
//  - Simultaneous rise and timeout in the same cycle: the rise wins.
//  - Reset mid-period or mid-divide: the result is discarded and no sample_valid is emitted.
// STRUCTURE
//  - pwm_audio_pkg: CNT_W=14, SAMPLE_W=8, CYCLE, SCALE, and the FSM state enum
//    (HUNT/TRACK/SILENT). This package is shared with the PWM sender.
//  - Sub-module const_div: restoring divider with a constant divisor.
//    Ports: clk, rst, start, dividend[13:0], busy, done, quot[13:0].
//  - Top level: synchronizer, edge detect, counters, FSM, clamp, and output registers.
// TESTING
//  1. Reset: hold rst=0 while toggling pwm_in -> all outputs are 0. Release -> state is HUNT
//     and no valid is emitted until the 2nd rise.
//  2. Ideal sender, sample=128 (high 6271 clocks, period 12501) -> 1st rise gives no
//     output. 2nd rise gives sample_valid 15 clocks later with sample_out=128 and locked=1.
//  3. Sweep samples 1, 49, 200, 255 (high 48 / 2400 / 9799 / 12494 clocks) -> the outputs
//     are 1, 49, 200, 255, one per period.
//  4. Lock at sample 100, then hold pwm_in low -> sample 0 at 12565 clocks after the last
//     rise, then every 12501 clocks. A later rise returns to TRACK with no period_err.
//  5. Period of 12000 clocks, or pwm_in stuck high for 12565 clocks -> period_err pulse,
//     locked=0, and no sample_valid.
//  6. Assert rst=0 during the divide window (5 clocks after capture) -> no sample_valid,
//     and sample_out=0.

Source files
------------

// File: rtl/pwm_audio_pkg.sv
// Constants, state encoding and sample clamp shared by the audio PWM sender and receiver.
package pwm_audio_pkg;

    localparam int CNT_W    = 14;
    localparam int SAMPLE_W = 8;
    localparam int CYCLE    = 12500;
    localparam int SCALE    = 49;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        TRACK  = 2'd1,
        SILENT = 2'd2
    } demod_state_t;

    function automatic logic [SAMPLE_W-1:0] clamp_sample(input logic [CNT_W-1:0] q);
        if (q > CNT_W'((1 << SAMPLE_W) - 1)) begin
            return '1;
        end
        return q[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/const_div.sv
// Restoring divider by a constant. The first step is taken on the start edge, so the
// quotient and the done pulse appear CNT_W-1 cycles after start is accepted.
module const_div
    import pwm_audio_pkg::*;
#(
    parameter int DIVISOR = SCALE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] dividend,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] quot
);

    localparam logic [CNT_W-1:0] DIV_C = CNT_W'(DIVISOR);

    logic [CNT_W-1:0] rem_q;
    logic [CNT_W-1:0] rem_src;
    logic [CNT_W-1:0] shift_src;
    logic [CNT_W-1:0] rem_n;
    logic [CNT_W-1:0] shift_n;
    logic [CNT_W:0]   trial;
    logic             q_bit;
    logic [3:0]       step_cnt;

    // quot doubles as the dividend shift register while the divide runs
    always_comb begin
        rem_src   = busy ? rem_q : '0;
        shift_src = busy ? quot  : dividend;
        trial     = {rem_src, shift_src[CNT_W-1]};
        q_bit     = 1'b0;
        rem_n     = trial[CNT_W-1:0];
        if (trial >= {1'b0, DIV_C}) begin
            q_bit = 1'b1;
            rem_n = trial[CNT_W-1:0] - DIV_C;
        end
        shift_n = {shift_src[CNT_W-2:0], q_bit};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            step_cnt <= '0;
            rem_q    <= '0;
            quot     <= '0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                rem_q    <= rem_n;
                quot     <= shift_n;
                step_cnt <= step_cnt - 4'd1;
                if (step_cnt == 4'd1) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end else if (start) begin
                rem_q    <= rem_n;
                quot     <= shift_n;
                step_cnt <= 4'(CNT_W - 1);
                busy     <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_audio_demod.sv
// Audio PWM receiver: measures high time per period and recovers one 8-bit sample per period.
//
//  state  | meaning
//  HUNT   | waiting for the first rise to anchor the period counters
//  TRACK  | measuring periods; each in-tolerance rise captures the high time
//  SILENT | input idle low while locked; a zero sample is emitted every period
module pwm_audio_demod
    import pwm_audio_pkg::*;
#(
    parameter int CYCLE  = pwm_audio_pkg::CYCLE,
    parameter int SCALE  = pwm_audio_pkg::SCALE,
    parameter int TOL    = 64,
    parameter int SYNC_N = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pwm_in,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    output logic                locked,
    output logic                period_err
);

    localparam logic [CNT_W-1:0] PER_MIN = CNT_W'(CYCLE + 1 - TOL);
    localparam logic [CNT_W-1:0] PER_MAX = CNT_W'(CYCLE + 1 + TOL);
    localparam logic [CNT_W-1:0] SIL_TC  = CNT_W'(CYCLE);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] ROUND   = CNT_W'(SCALE / 2 + 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [SYNC_N-1:0] sync_q;
    logic              pwm_s;
    logic              pwm_d;
    logic              rise;
    logic [CNT_W-1:0]  per_cnt;
    logic [CNT_W-1:0]  hi_cnt;
    logic [CNT_W-1:0]  dividend;
    logic [CNT_W-1:0]  div_q;
    logic              div_busy;
    logic              div_done;

    demod_state_t state;
    demod_state_t state_n;
    logic         anchor;
    logic         per_clr;
    logic         capture;
    logic         err_n;
    logic         zero_n;
    logic         lock_set;
    logic         lock_clr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '0;
            pwm_d  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_N-2:0], pwm_in};
            pwm_d  <= pwm_s;
        end
    end

    assign pwm_s    = sync_q[SYNC_N-1];
    assign rise     = pwm_s & ~pwm_d;
    assign dividend = hi_cnt + ROUND;

    // the anchor cycle itself is high, so both counters restart at 1
    always_ff @(posedge clk) begin
        if (!rst) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else if (anchor) begin
            per_cnt <= ONE;
            hi_cnt  <= ONE;
        end else begin
            if (per_clr) begin
                per_cnt <= '0;
            end else if (per_cnt != CNT_MAX) begin
                per_cnt <= per_cnt + ONE;
            end
            if (pwm_s && (hi_cnt != CNT_MAX)) begin
                hi_cnt <= hi_cnt + ONE;
            end
        end
    end

    always_comb begin
        state_n  = state;
        anchor   = 1'b0;
        per_clr  = 1'b0;
        capture  = 1'b0;
        err_n    = 1'b0;
        zero_n   = 1'b0;
        lock_set = 1'b0;
        lock_clr = 1'b0;
        unique case (state)
            HUNT: begin
                if (rise) begin
                    anchor  = 1'b1;
                    state_n = TRACK;
                end
            end
            TRACK: begin
                if (rise) begin
                    anchor = 1'b1;
                    if ((per_cnt >= PER_MIN) && (per_cnt <= PER_MAX)) begin
                        if (div_busy) begin
                            err_n = 1'b1;
                        end else begin
                            capture  = 1'b1;
                            lock_set = 1'b1;
                        end
                    end else begin
                        err_n    = 1'b1;
                        lock_clr = 1'b1;
                    end
                end else if (per_cnt == PER_MAX) begin
                    if (!pwm_s && locked) begin
                        zero_n  = 1'b1;
                        per_clr = 1'b1;
                        state_n = SILENT;
                    end else begin
                        err_n    = 1'b1;
                        lock_clr = 1'b1;
                        state_n  = HUNT;
                    end
                end
            end
            SILENT: begin
                if (rise) begin
                    anchor  = 1'b1;
                    state_n = TRACK;
                end else if (per_cnt == SIL_TC) begin
                    zero_n  = 1'b1;
                    per_clr = 1'b1;
                end
            end
            default: state_n = HUNT;
        endcase
    end

    const_div #(
        .DIVISOR(SCALE)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .start   (capture),
        .dividend(dividend),
        .busy    (div_busy),
        .done    (div_done),
        .quot    (div_q)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= HUNT;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            locked       <= 1'b0;
            period_err   <= 1'b0;
        end else begin
            state        <= state_n;
            period_err   <= err_n;
            sample_valid <= div_done | zero_n;
            if (div_done) begin
                sample_out <= clamp_sample(div_q);
            end else if (zero_n) begin
                sample_out <= '0;
            end
            if (lock_clr) begin
                locked <= 1'b0;
            end else if (lock_set) begin
                locked <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_audio_demod.sv
// Scoreboard bench for pwm_audio_demod: period-level reference model, randomized samples.
module tb_pwm_audio_demod;

    localparam int CYC  = 1280;
    localparam int SC   = 5;
    localparam int TL   = 16;
    localparam int SN   = 2;
    localparam int P0   = CYC + 1;
    localparam int TOUT = P0 + TL;
    localparam int LAT  = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pwm_in = 1'b0;
    logic [7:0] sample_out;
    logic       sample_valid;
    logic       locked;
    logic       period_err;

    pwm_audio_demod #(
        .CYCLE (CYC),
        .SCALE (SC),
        .TOL   (TL),
        .SYNC_N(SN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pwm_in      (pwm_in),
        .sample_out  (sample_out),
        .sample_valid(sample_valid),
        .locked      (locked),
        .period_err  (period_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int val;
        int at;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   err_seen = 0;
    int   exp_err = 0;
    int   hold_exp = 0;

    // reference model state, one step per PWM period
    bit trk = 0;
    bit lk = 0;
    bit have_prev = 0;
    int prev_h = 0;
    int prev_l = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int decode(input int h);
        int q;
        q = (h + 1 + SC / 2) / SC;
        return (q > 255) ? 255 : q;
    endfunction

    task automatic push_exp(input int val, input int at);
        exp_t e;
        e.val = val;
        e.at  = at;
        sb.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_rise(input int rc);
        int dev;
        if (trk && have_prev) begin
            dev = (prev_l > P0) ? prev_l - P0 : P0 - prev_l;
            if (dev <= TL) begin
                push_exp(decode(prev_h), rc + SN + LAT);
                lk = 1;
            end else begin
                exp_err++;
                lk = 0;
            end
        end
        trk = 1;
        have_prev = 0;
    endtask

    // one period: rise now, high for h clocks, next rise l clocks after this one
    task automatic drive_period(input int h, input int l);
        int rc;
        rc = cyc;
        model_rise(rc);
        if (trk && l > TOUT) begin
            if (h <= TOUT && lk) begin
                for (int t = rc + SN + TOUT + 1; t - 1 < rc + l + SN; t += P0)
                    push_exp(0, t);
            end else begin
                exp_err++;
                lk = 0;
                trk = 0;
            end
        end else begin
            have_prev = 1;
            prev_h = h;
            prev_l = l;
        end
        pwm_in = 1'b1;
        for (int i = 1; i < l; i++) begin
            next_cycle();
            if (i == h) pwm_in = 1'b0;
        end
        next_cycle();
        chk("locked", locked, lk);
        chk("period_err_count", err_seen, exp_err);
    endtask

    task automatic reset_mid_divide();
        pwm_in = 1'b1;
        repeat (SN + 6) next_cycle();
        rst = 1'b0;
        pwm_in = 1'b0;
        hold_exp = 0;
        repeat (3) next_cycle();
        rst = 1'b1;
        trk = 0;
        lk = 0;
        have_prev = 0;
        chk("reset_sample_out", sample_out, 0);
        chk("reset_locked", locked, 0);
        repeat (30) next_cycle();
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (period_err) err_seen++;
        if (sample_valid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL spurious_valid: sample %0d at cycle %0d, none expected", sample_out, cyc);
            end else begin
                e = sb.pop_front();
                chk("sample_value", sample_out, e.val);
                chk("sample_cycle", cyc, e.at);
                hold_exp = e.val;
            end
        end else if (rst) begin
            chk("sample_hold", sample_out, hold_exp);
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: bench did not complete, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : stim
        int s;
        repeat (2) next_cycle();
        for (int i = 0; i < 16; i++) begin
            pwm_in = 1'($urandom_range(0, 1));
            next_cycle();
            chk("rst_sample_out", sample_out, 0);
            chk("rst_sample_valid", sample_valid, 0);
            chk("rst_locked", locked, 0);
            chk("rst_period_err", period_err, 0);
        end
        pwm_in = 1'b0;
        repeat (4) next_cycle();
        rst = 1'b1;
        repeat (5) next_cycle();

        drive_period(128 * SC - 1, P0);
        drive_period(1 * SC - 1, P0);
        drive_period(49 * SC - 1, P0 + 3);
        drive_period(200 * SC - 1, P0 - TL);
        drive_period(255 * SC - 1, P0 + TL);
        for (int i = 0; i < 4; i++) begin
            s = $urandom_range(1, 250);
            drive_period(s * SC - 1, P0 + $urandom_range(0, 2 * TL) - TL);
        end
        drive_period(1290, TOUT);

        drive_period(100 * SC - 1, P0);
        drive_period(100 * SC - 1, 4000);
        s = $urandom_range(1, 250);
        drive_period(s * SC - 1, P0);

        s = $urandom_range(1, 190);
        drive_period(s * SC - 1, 1000);
        drive_period(1400, 1500);
        s = $urandom_range(1, 250);
        drive_period(s * SC - 1, P0);
        s = $urandom_range(1, 250);
        drive_period(s * SC - 1, P0);

        reset_mid_divide();

        for (int i = 0; i < 2; i++) begin
            s = $urandom_range(1, 250);
            drive_period(s * SC - 1, P0 + $urandom_range(0, 2 * TL) - TL);
        end
        drive_period(10, 20);
        repeat (40) next_cycle();

        chk("outstanding_expected", sb.size(), 0);
        chk("final_period_err_count", err_seen, exp_err);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
